seg7_scan_reader: RTL and testbench

- Reads back a multiplexed, time-scanned 7-segment display bus and recovers the hex digits being shown.
- Input is the segment lines and digit enables produced by the team's hex-to-7-segment decoder plus display scanner; this block is the inverse function.
- It synchronises and debounces the bus, decodes each segment pattern to a nibble, assembles one nibble per digit position into a frame, and presents the frame on a valid/ready handshake.
- Used for display loop-back checking and for tapping an external display.

---
 rtl/seg7_scan_reader.sv | 104 ++++++++++
 tb/tb_seg7_scan_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers hex digits from a scanned 7-segment bus and
// presents each complete frame of NDIG digits on a valid/ready handshake.
module seg7_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   an,
    output logic [4*NDIG-1:0] frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              digit_err,
    output logic              frame_drop
);
    typedef enum logic [1:0] {IDLE, COUNT, LOCKED} state_t;
    localparam logic [7:0] CMAX = 8'(STABLE_CYC - 1);
    state_t state, state_nx;
    logic [6:0] seg_m, seg_s;
    logic [NDIG-1:0] an_m, an_s, sel, mask;
    logic [NDIG+6:0] s_prev;
    logic [7:0] cnt, cnt_nx;
    logic [4*NDIG-1:0] slots;
    logic [3:0] nib;
    logic changed, onehot, accept, legal, wr, complete, load;
    always_comb begin
        sel      = ~an_s;
        onehot   = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
        changed  = {an_s, seg_s} != s_prev;
        cnt_nx   = changed ? 8'd0 : (cnt == CMAX ? cnt : cnt + 8'd1);
        complete = &mask;
        load     = complete && (!frame_valid || frame_ready);
        legal    = 1'b1;
        case (seg_s)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: begin
                nib   = 4'h0;
                legal = 1'b0;
            end
        endcase
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE:    state_nx = onehot ? COUNT : IDLE;
            COUNT:   if (changed) state_nx = onehot ? COUNT : IDLE;
                     else if (cnt_nx == CMAX) begin
                         accept   = 1'b1;
                         state_nx = LOCKED;
                     end
            LOCKED:  if (changed) state_nx = onehot ? COUNT : IDLE;
            default: state_nx = IDLE;
        endcase
        wr = accept && legal;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m       <= '0;
            seg_s       <= '0;
            an_m        <= '1;
            an_s        <= '1;
            s_prev      <= {{NDIG{1'b1}}, 7'h00};
            cnt         <= '0;
            mask        <= '0;
            slots       <= '0;
            state       <= IDLE;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            digit_err   <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            seg_m       <= seg;
            seg_s       <= seg_m;
            an_m        <= an;
            an_s        <= an_m;
            s_prev      <= {an_s, seg_s};
            cnt         <= cnt_nx;
            state       <= state_nx;
            digit_err   <= accept && !legal;
            frame_drop  <= complete && !load;
            mask        <= complete ? '0 : (wr ? mask | sel : mask);
            for (int i = 0; i < NDIG; i++)
                if (wr && sel[i]) slots[4*i +: 4] <= nib;
            // a frame loading in the same cycle as a consume keeps valid high
            frame_valid <= load ? 1'b1 : (frame_ready ? 1'b0 : frame_valid);
            if (load) frame_data <= slots;
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed checks of digit capture, framing, handshake,
// error/drop pulses and asynchronous reset for seg7_scan_reader.
module tb_seg7_scan_reader;
    logic        clk = 1'b0, rst_n = 1'b1, frame_ready = 1'b0;
    logic [6:0]  seg = '0;
    logic [3:0]  an = 4'hF;
    logic [15:0] frame_data, last_data = '0;
    logic        frame_valid, digit_err, frame_drop, fv_q = 1'b0;
    int ncmp = 0, nerr = 0, frames = 0, drops = 0, errs = 0;
    int f0, e0, d0;

    localparam logic [27:0] S4321 = {7'h66, 7'h4F, 7'h5B, 7'h06};
    localparam logic [27:0] SFBA0 = {7'h71, 7'h7C, 7'h77, 7'h3F};
    localparam logic [27:0] SFEDC = {7'h71, 7'h79, 7'h5E, 7'h39};

    always #5 clk = ~clk;

    seg7_scan_reader #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .digit_err(digit_err), .frame_drop(frame_drop)
    );

    // event monitor samples on the falling edge, inputs move 1ns later
    always @(negedge clk) begin
        if (frame_valid && !fv_q) frames++;
        if (frame_drop) drops++;
        if (digit_err) errs++;
        if (frame_valid && frame_ready) last_data = frame_data;
        fv_q = frame_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        step(n);
    endtask

    task automatic scan(input logic [27:0] s, input int n);
        for (int i = 0; i < 4; i++) show(4'(~(4'b0001 << i)), s[7*i +: 7], n);
        show(4'hF, 7'h00, 5);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step(2);
        check("rst_data", 32'(frame_data), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(digit_err), 32'h0);
        check("rst_drop", 32'(frame_drop), 32'h0);
        rst_n = 1'b1;
        frame_ready = 1'b1;
        step(2);

        f0 = frames; e0 = errs;
        scan(S4321, 10);
        check("t1_frames", 32'(frames - f0), 32'd1);
        check("t1_data", 32'(last_data), 32'h4321);
        check("t1_errs", 32'(errs - e0), 32'd0);
        check("t1_valid_low", 32'(frame_valid), 32'h0);

        f0 = frames; last_data = '0;
        scan(S4321, 3);
        show(4'hF, 7'h00, 5);
        check("t2_short_frames", 32'(frames - f0), 32'd0);
        scan(S4321, 5);
        check("t2_long_frames", 32'(frames - f0), 32'd1);
        check("t2_data", 32'(last_data), 32'h4321);

        f0 = frames; e0 = errs;
        show(4'hE, 7'h06, 10);
        show(4'hD, 7'h5B, 10);
        show(4'hB, 7'h7B, 10);
        show(4'h7, 7'h66, 10);
        show(4'hF, 7'h00, 5);
        check("t3_errs", 32'(errs - e0), 32'd1);
        check("t3_no_frame", 32'(frames - f0), 32'd0);
        show(4'hB, 7'h7F, 10);
        show(4'hF, 7'h00, 5);
        check("t3_frames", 32'(frames - f0), 32'd1);
        check("t3_data", 32'(last_data), 32'h4821);

        frame_ready = 1'b0;
        f0 = frames; d0 = drops;
        scan(SFBA0, 10);
        check("t4_valid", 32'(frame_valid), 32'h1);
        check("t4_data", 32'(frame_data), 32'hFBA0);
        scan(S4321, 10);
        check("t4_drops", 32'(drops - d0), 32'd1);
        check("t4_held_data", 32'(frame_data), 32'hFBA0);
        check("t4_held_valid", 32'(frame_valid), 32'h1);
        frame_ready = 1'b1;
        step(1);
        check("t4_valid_fall", 32'(frame_valid), 32'h0);
        check("t4_frames", 32'(frames - f0), 32'd1);

        f0 = frames; e0 = errs;
        show(4'b1100, 7'h7F, 20);
        show(4'hF, 7'h7F, 20);
        check("t5_idle_errs", 32'(errs - e0), 32'd0);
        check("t5_idle_frames", 32'(frames - f0), 32'd0);
        show(4'hB, 7'h7B, 10);
        show(4'hB, 7'h7F, 1);
        show(4'hB, 7'h7B, 10);
        check("t5_reaccept_errs", 32'(errs - e0), 32'd2);
        show(4'hE, 7'h06, 10);
        show(4'hE, 7'h07, 1);
        show(4'hE, 7'h06, 10);
        frame_ready = 1'b0;
        show(4'hD, 7'h5B, 10);
        show(4'hB, 7'h4F, 10);
        show(4'h7, 7'h66, 10);
        show(4'hF, 7'h00, 5);
        check("t5_frames", 32'(frames - f0), 32'd1);
        check("t5_data", 32'(frame_data), 32'h4321);
        check("t5_valid", 32'(frame_valid), 32'h1);

        show(4'hE, 7'h6D, 10);
        show(4'hD, 7'h7D, 10);
        show(4'hB, 7'h07, 10);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data", 32'(frame_data), 32'h0);
        check("t6_rst_valid", 32'(frame_valid), 32'h0);
        check("t6_rst_err", 32'(digit_err), 32'h0);
        check("t6_rst_drop", 32'(frame_drop), 32'h0);
        show(4'hF, 7'h00, 2);
        rst_n = 1'b1;
        frame_ready = 1'b1;
        step(2);
        f0 = frames; d0 = drops; last_data = '0;
        scan(SFEDC, 10);
        check("t6_frames", 32'(frames - f0), 32'd1);
        check("t6_data", 32'(last_data), 32'hFEDC);
        check("t6_drops", 32'(drops - d0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
